alu_share_ctrl: RTL and testbench

// - Shares the single combinational 16-bit `alu` between two requesters (r0, r1) with round-robin arbitration.
// - Registers operands, drives the ALU, and holds each result plus its flags in a per-requester response buffer.
// - Keeps a processor-status flag register (PSR) for branch logic.
// - Sits between the decode/issue logic and the `alu` instance (ports a, b, aluControl, result, C, L, F, Z, N).

---
 rtl/alu_share_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters (round-robin),
// buffering each result per requester. Define ALU_PSR_EN to keep the PSR flag register.

module alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluControl,
    output logic [WIDTH-1:0] result,
    output logic             C,
    output logic             L,
    output logic             F,
    output logic             Z,
    output logic             N
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        C      = 1'b0;
        L      = 1'b0;
        F      = 1'b0;
        case (aluControl)
            4'b0000, 4'b1000: begin
                result = sum[WIDTH-1:0];
                C      = sum[WIDTH];
                F      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001, 4'b0010: begin
                // C reports borrow; L is the unsigned a<b compare
                result = diff[WIDTH-1:0];
                C      = diff[WIDTH];
                L      = diff[WIDTH];
                F      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0011: result = a & b;
            4'b0100: result = a | b;
            4'b0101: result = a ^ b;
            default: result = '0;
        endcase
        Z = (result == '0);
        N = result[WIDTH-1];
    end
endmodule

module alu_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [3:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_result,
    output logic [4:0]       r0_flags,
    output logic             r0_err,
    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [3:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_result,
    output logic [4:0]       r1_flags,
    output logic             r1_err,
    output logic [4:0]       psr_flags
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_q, state_d;
    logic                       rr_q, rr_d;
    logic [3:0]                 op_q, op_d;
    logic [WIDTH-1:0]           a_q, a_d;
    logic [WIDTH-1:0]           b_q, b_d;
    logic                       id_q, id_d;
    logic [1:0]                 rsp_valid_q, rsp_valid_d;
    logic [1:0][WIDTH-1:0]      res_q, res_d;
    logic [1:0][4:0]            flags_q, flags_d;
    logic [1:0]                 err_q, err_d;

    logic                       elig0, elig1;
    logic                       grant_vld, grant_id;
    logic [WIDTH-1:0]           alu_res;
    logic                       alu_c, alu_l, alu_f, alu_z, alu_n;
    logic [4:0]                 alu_flags;
    logic                       op_arith, op_logic, op_legal;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a          (a_q),
        .b          (b_q),
        .aluControl (op_q),
        .result     (alu_res),
        .C          (alu_c),
        .L          (alu_l),
        .F          (alu_f),
        .Z          (alu_z),
        .N          (alu_n)
    );

    assign alu_flags = {alu_c, alu_l, alu_f, alu_z, alu_n};
    assign op_arith  = op_q inside {4'b0000, 4'b1000, 4'b0001, 4'b0010};
    assign op_logic  = op_q inside {4'b0011, 4'b0100, 4'b0101};
    assign op_legal  = op_arith | op_logic;

    // Eligibility uses the registered buffer state, so a drain only frees the requester next cycle.
    assign elig0 = r0_req_valid & ~rsp_valid_q[0];
    assign elig1 = r1_req_valid & ~rsp_valid_q[1];

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (elig0 && elig1) begin
            grant_vld = 1'b1;
            grant_id  = rr_q;
        end else if (elig0) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (elig1) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign r0_req_ready = (state_q == IDLE) & grant_vld & ~grant_id;
    assign r1_req_ready = (state_q == IDLE) & grant_vld & grant_id;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        err_d       = err_q;

        if (rsp_valid_q[0] && r0_rsp_ready) begin
            rsp_valid_d[0] = 1'b0;
            res_d[0]       = '0;
            flags_d[0]     = '0;
            err_d[0]       = 1'b0;
        end
        if (rsp_valid_q[1] && r1_rsp_ready) begin
            rsp_valid_d[1] = 1'b0;
            res_d[1]       = '0;
            flags_d[1]     = '0;
            err_d[1]       = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    op_d    = grant_id ? r1_op : r0_op;
                    a_d     = grant_id ? r1_a  : r0_a;
                    b_d     = grant_id ? r1_b  : r0_b;
                    id_d    = grant_id;
                    rr_d    = ~grant_id;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The target buffer was empty at grant, so no drain can collide with this write.
                res_d[id_q]       = op_legal ? alu_res : '0;
                flags_d[id_q]     = op_legal ? alu_flags : 5'b0;
                err_d[id_q]       = ~op_legal;
                rsp_valid_d[id_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_q        <= (RR_INIT != 0);
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end

    assign r0_rsp_valid = rsp_valid_q[0];
    assign r1_rsp_valid = rsp_valid_q[1];
    assign r0_result    = res_q[0];
    assign r1_result    = res_q[1];
    assign r0_flags     = flags_q[0];
    assign r1_flags     = flags_q[1];
    assign r0_err       = err_q[0];
    assign r1_err       = err_q[1];

`ifdef ALU_PSR_EN
    logic [4:0] psr_q, psr_d;

    // Logical ops only refresh Z and N; carry/low/overflow keep their last arithmetic value.
    always_comb begin
        psr_d = psr_q;
        if (state_q == BUSY) begin
            if (op_arith) begin
                psr_d = alu_flags;
            end else if (op_logic) begin
                psr_d[1:0] = alu_flags[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr_flags = psr_q;
`else
    assign psr_flags = 5'b0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl; PSR expectations follow ALU_PSR_EN.
module tb_alu_share_ctrl;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADD2 = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready, r0_err;
    logic [3:0]  r0_op;
    logic [15:0] r0_a, r0_b, r0_result;
    logic [4:0]  r0_flags;
    logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready, r1_err;
    logic [3:0]  r1_op;
    logic [15:0] r1_a, r1_b, r1_result;
    logic [4:0]  r1_flags;
    logic [4:0]  psr_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(16), .RR_INIT(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .r0_req_valid (r0_req_valid),
        .r0_req_ready (r0_req_ready),
        .r0_op        (r0_op),
        .r0_a         (r0_a),
        .r0_b         (r0_b),
        .r0_rsp_valid (r0_rsp_valid),
        .r0_rsp_ready (r0_rsp_ready),
        .r0_result    (r0_result),
        .r0_flags     (r0_flags),
        .r0_err       (r0_err),
        .r1_req_valid (r1_req_valid),
        .r1_req_ready (r1_req_ready),
        .r1_op        (r1_op),
        .r1_a         (r1_a),
        .r1_b         (r1_b),
        .r1_rsp_valid (r1_rsp_valid),
        .r1_rsp_ready (r1_rsp_ready),
        .r1_result    (r1_result),
        .r1_flags     (r1_flags),
        .r1_err       (r1_err),
        .psr_flags    (psr_flags)
    );

    function automatic logic [52:0] all_outs();
        return {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, r0_result, r1_result,
                r0_flags, r1_flags, r0_err, r1_err, psr_flags};
    endfunction

    function automatic logic [4:0] exp_psr(input logic [4:0] v);
`ifdef ALU_PSR_EN
        return v;
`else
        return 5'b0;
`endif
    endfunction

    task automatic drive_req(input bit id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            r1_op = op; r1_a = a; r1_b = b; r1_req_valid = 1'b1;
        end else begin
            r0_op = op; r0_a = a; r0_b = b; r0_req_valid = 1'b1;
        end
    endtask

    task automatic drop_req(input bit id);
        if (id) r1_req_valid = 1'b0;
        else    r0_req_valid = 1'b0;
    endtask

    // Returns just after the accepting edge (state is BUSY).
    task automatic send(input bit id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output bit ok);
        ok = 1'b0;
        drive_req(id, op, a, b);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? r1_req_ready : r0_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 drop_req(id);
    endtask

    // Returns at the negedge where the response is first visible.
    task automatic wait_rsp(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? r1_rsp_valid : r0_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        r0_req_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0; r0_rsp_ready = 1'b1;
        r1_req_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1'b1;
        #12;
        n_checks++;
        if (all_outs() !== 53'd0) begin
            n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs() !== 53'd0) begin
            n_fail++; $display("FAIL post_reset_outs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_add_latency();
        bit ok;
        send(1'b0, OP_ADD, 16'h0003, 16'h0001, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL add_accept: got %b expected 1", ok); end
        @(negedge clk);
        n_checks++;
        if (r0_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_early_valid: got %b expected 0", r0_rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({r0_rsp_valid, r0_result, r0_err, r0_flags} !== {1'b1, 16'h0004, 1'b0, 5'b00000}) begin
            n_fail++;
            $display("FAIL add_rsp: got v=%b r=%h e=%b f=%b expected v=1 r=0004 e=0 f=00000",
                     r0_rsp_valid, r0_result, r0_err, r0_flags);
        end
        n_checks++;
        if (psr_flags !== exp_psr(5'b00000)) begin
            n_fail++; $display("FAIL add_psr: got %b expected %b", psr_flags, exp_psr(5'b00000));
        end
        @(negedge clk);
        n_checks++;
        if (r0_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_drain: got %b expected 0", r0_rsp_valid);
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        pulse_reset();
        @(posedge clk);
        #1;
        drive_req(1'b0, OP_SUB, 16'h0003, 16'h0001);
        drive_req(1'b1, OP_CMP, 16'h0003, 16'h0003);
        @(negedge clk);
        n_checks++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rr_first: got r0/r1 ready %b%b expected 10", r0_req_ready, r1_req_ready);
        end
        @(posedge clk);
        #1 drop_req(1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({r0_rsp_valid, r0_result, r1_req_ready} !== {1'b1, 16'h0002, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_then_r1: got v=%b r=%h r1rdy=%b expected v=1 r=0002 r1rdy=1",
                     r0_rsp_valid, r0_result, r1_req_ready);
        end
        @(posedge clk);
        #1 drop_req(1'b1);
        wait_rsp(1'b1, ok);
        n_checks++;
        if ({ok, r1_flags, r1_err} !== {1'b1, 5'b00010, 1'b0}) begin
            n_fail++; $display("FAIL cmp_rsp: got ok=%b f=%b e=%b expected ok=1 f=00010 e=0", ok, r1_flags, r1_err);
        end
        n_checks++;
        if (psr_flags !== exp_psr(5'b00010)) begin
            n_fail++; $display("FAIL cmp_psr: got %b expected %b", psr_flags, exp_psr(5'b00010));
        end
    endtask

    task automatic test_full_buffer();
        bit ok, blocked, r1_seen, got1;
        logic [15:0] r1_res;
        blocked = 1'b0; got1 = 1'b0; r1_res = '0;
        @(posedge clk);
        #1 r0_rsp_ready = 1'b0;
        send(1'b0, OP_ADD, 16'h0005, 16'h0006, ok);
        wait_rsp(1'b0, ok);
        n_checks++;
        if ({ok, r0_result} !== {1'b1, 16'h000B}) begin
            n_fail++; $display("FAIL hold_first: got ok=%b r=%h expected ok=1 r=000b", ok, r0_result);
        end
        @(posedge clk);
        #1;
        drive_req(1'b0, OP_OR, 16'h00F0, 16'h000F);
        drive_req(1'b1, OP_XOR, 16'h0002, 16'h0003);
        @(negedge clk);
        r1_seen = r1_req_ready;
        if (r0_req_ready) blocked = 1'b1;
        @(posedge clk);
        #1 drop_req(1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (r0_req_ready) blocked = 1'b1;
            if (r1_rsp_valid && !got1) begin
                got1 = 1'b1;
                r1_res = r1_result;
            end
        end
        n_checks++;
        if ({r1_seen, blocked} !== 2'b10) begin
            n_fail++; $display("FAIL full_block: got r1rdy=%b r0granted=%b expected 1 0", r1_seen, blocked);
        end
        n_checks++;
        if ({got1, r1_res} !== {1'b1, 16'h0001}) begin
            n_fail++; $display("FAIL xor_rsp: got ok=%b r=%h expected ok=1 r=0001", got1, r1_res);
        end
        n_checks++;
        if ({r0_rsp_valid, r0_result} !== {1'b1, 16'h000B}) begin
            n_fail++; $display("FAIL hold_stable: got v=%b r=%h expected v=1 r=000b", r0_rsp_valid, r0_result);
        end
        @(posedge clk);
        #1 r0_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (r0_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL drain_same_cycle: got %b expected 0", r0_req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({r0_rsp_valid, r0_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL drain_next: got v=%b rdy=%b expected v=0 rdy=1", r0_rsp_valid, r0_req_ready);
        end
        @(posedge clk);
        #1 drop_req(1'b0);
        wait_rsp(1'b0, ok);
        n_checks++;
        if ({ok, r0_result, r0_flags} !== {1'b1, 16'h00FF, 5'b00000}) begin
            n_fail++; $display("FAIL or_rsp: got ok=%b r=%h f=%b expected ok=1 r=00ff f=00000", ok, r0_result, r0_flags);
        end
    endtask

    task automatic test_wrap_and_logic();
        bit ok;
        send(1'b0, OP_ADD, 16'hFFFF, 16'h0001, ok);
        wait_rsp(1'b0, ok);
        n_checks++;
        if ({ok, r0_result, r0_flags} !== {1'b1, 16'h0000, 5'b10010}) begin
            n_fail++; $display("FAIL wrap_rsp: got ok=%b r=%h f=%b expected ok=1 r=0000 f=10010", ok, r0_result, r0_flags);
        end
        n_checks++;
        if (psr_flags !== exp_psr(5'b10010)) begin
            n_fail++; $display("FAIL wrap_psr: got %b expected %b", psr_flags, exp_psr(5'b10010));
        end
        send(1'b0, OP_AND, 16'h0002, 16'h0003, ok);
        wait_rsp(1'b0, ok);
        n_checks++;
        if ({ok, r0_result, r0_flags} !== {1'b1, 16'h0002, 5'b00000}) begin
            n_fail++; $display("FAIL and_rsp: got ok=%b r=%h f=%b expected ok=1 r=0002 f=00000", ok, r0_result, r0_flags);
        end
        n_checks++;
        if (psr_flags !== exp_psr(5'b10000)) begin
            n_fail++; $display("FAIL and_psr: got %b expected %b", psr_flags, exp_psr(5'b10000));
        end
    endtask

    task automatic test_illegal();
        bit ok;
        send(1'b1, 4'b0111, 16'h1234, 16'h1111, ok);
        wait_rsp(1'b1, ok);
        n_checks++;
        if ({ok, r1_err, r1_result, r1_flags} !== {1'b1, 1'b1, 16'h0000, 5'b00000}) begin
            n_fail++;
            $display("FAIL illegal_rsp: got ok=%b e=%b r=%h f=%b expected ok=1 e=1 r=0000 f=00000",
                     ok, r1_err, r1_result, r1_flags);
        end
        n_checks++;
        if (psr_flags !== exp_psr(5'b10000)) begin
            n_fail++; $display("FAIL illegal_psr: got %b expected %b", psr_flags, exp_psr(5'b10000));
        end
        send(1'b0, 4'b1111, 16'h0005, 16'h0005, ok);
        wait_rsp(1'b0, ok);
        n_checks++;
        if ({ok, r0_err} !== 2'b11) begin
            n_fail++; $display("FAIL illegal_r0: got ok=%b e=%b expected 1 1", ok, r0_err);
        end
        @(posedge clk);
        #1;
        drive_req(1'b0, OP_ADD, 16'h0001, 16'h0001);
        drive_req(1'b1, OP_ADD2, 16'h0007, 16'h0008);
        @(negedge clk);
        n_checks++;
        if ({r0_req_ready, r1_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rr_after_illegal: got r0/r1 ready %b%b expected 01", r0_req_ready, r1_req_ready);
        end
        @(posedge clk);
        #1;
        drop_req(1'b0);
        drop_req(1'b1);
        wait_rsp(1'b1, ok);
        n_checks++;
        if ({ok, r1_result, r1_err} !== {1'b1, 16'h000F, 1'b0}) begin
            n_fail++; $display("FAIL add_1000: got ok=%b r=%h e=%b expected ok=1 r=000f e=0", ok, r1_result, r1_err);
        end
    endtask

    task automatic test_reset_busy();
        bit ok, seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, OP_ADD, 16'h0003, 16'h0003, ok);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 53'd0) begin
            n_fail++; $display("FAIL busy_reset_outs: got %h expected 0", all_outs());
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (r0_rsp_valid || r1_rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if ({seen, all_outs()} !== 54'd0) begin
            n_fail++; $display("FAIL busy_reset_discard: got seen=%b outs=%h expected 0", seen, all_outs());
        end
        @(posedge clk);
        #1;
        drive_req(1'b0, OP_ADD, 16'h0001, 16'h0002);
        drive_req(1'b1, OP_ADD, 16'h0001, 16'h0002);
        @(negedge clk);
        n_checks++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rr_reset: got r0/r1 ready %b%b expected 10", r0_req_ready, r1_req_ready);
        end
        @(posedge clk);
        #1;
        drop_req(1'b0);
        drop_req(1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_arbitration();
        test_full_buffer();
        test_wrap_and_logic();
        test_illegal();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
